// File: rtl/axi_lite_pkg.sv
// Shared constants and state types for the AXI4-Lite register responder.
package axi_lite_pkg;

  localparam int unsigned AXI_RESP_W = 3;

  localparam logic [AXI_RESP_W-1:0] RESP_OKAY   = AXI_RESP_W'(0);
  localparam logic [AXI_RESP_W-1:0] RESP_SLVERR = AXI_RESP_W'(2);

  localparam logic [3:0] REG0_OFF = 4'h0;
  localparam logic [3:0] REG1_OFF = 4'h4;
  localparam logic [3:0] REG2_OFF = 4'h8;
  localparam logic [3:0] REG3_OFF = 4'hC;

  typedef enum logic [1:0] {
    W_IDLE      = 2'd0,
    W_WAIT_DATA = 2'd1,
    W_WAIT_ADDR = 2'd2,
    W_RESP      = 2'd3
  } w_state_t;

  typedef enum logic [0:0] {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } r_state_t;

endpackage

// File: rtl/axi_lite_addr_decode.sv
// Combinational decode of a byte address into the 16-byte register window.
module axi_lite_addr_decode
  import axi_lite_pkg::*;
#(
  parameter int unsigned             ADDR_WIDTH = 8,
  parameter logic [ADDR_WIDTH-1:0]   BASE_ADDR  = '0
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic                  legal_c,
  output logic [1:0]            index_c,
  output logic                  writable_c
);

  logic [ADDR_WIDTH-1:0] offset;

  // Offset is taken modulo 2^ADDR_WIDTH; an address below the base is rejected separately.
  always_comb begin
    offset     = addr - BASE_ADDR;
    legal_c    = (addr >= BASE_ADDR) && (offset[ADDR_WIDTH-1:4] == '0) && (offset[1:0] == 2'b00);
    index_c    = offset[3:2];
    writable_c = legal_c && ((offset[3:0] == REG0_OFF) || (offset[3:0] == REG1_OFF));
  end

endmodule

// File: rtl/axi_lite_reg_slave.sv
// AXI4-Lite responder with two RW registers, a write counter and a constant ID register.
module axi_lite_reg_slave
  import axi_lite_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           ADDR_WIDTH = 8,
  parameter int unsigned           RESP_WIDTH = 3,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter logic [DATA_WIDTH-1:0] ID_VALUE   = DATA_WIDTH'(32'hA5A5_0001)
) (
  input  logic                    s_axi_aclk,
  input  logic                    s_axi_areset,
  input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [DATA_WIDTH/8:0]   s_axi_wstrb,
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  output logic [RESP_WIDTH-1:0]   s_axi_bresp,
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  output logic [DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [RESP_WIDTH-1:0]   s_axi_rresp,
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready
);

  localparam int unsigned NBYTES = DATA_WIDTH / 8;

  w_state_t w_state_q, w_state_d;
  r_state_t r_state_q, r_state_d;

  logic [ADDR_WIDTH-1:0] aw_addr_q;
  logic [DATA_WIDTH-1:0] w_data_q;
  logic [NBYTES-1:0]     w_strb_q;
  logic [DATA_WIDTH-1:0] reg0_q, reg1_q, reg2_q;

  logic                  aw_hs_c, w_hs_c, ar_hs_c;
  logic                  commit_c, latch_aw_c, latch_w_c;
  logic [ADDR_WIDTH-1:0] wr_addr_c;
  logic [DATA_WIDTH-1:0] wr_data_c;
  logic [NBYTES-1:0]     wr_strb_c;
  logic                  wr_legal_c, wr_writable_c;
  logic [1:0]            wr_index_c;
  logic                  ar_legal_c, ar_writable_unused_c;
  logic [1:0]            ar_index_c;
  logic [DATA_WIDTH-1:0] rd_mux_c;
  logic                  wstrb_unused_c;

  logic                  awready_d, wready_d, bvalid_d, arready_d, rvalid_d;
  logic [RESP_WIDTH-1:0] bresp_d, rresp_d;
  logic [DATA_WIDTH-1:0] rdata_d;

  // Handshakes and selection between live and latched write halves.
  always_comb begin
    aw_hs_c        = s_axi_awvalid && s_axi_awready;
    w_hs_c         = s_axi_wvalid && s_axi_wready;
    ar_hs_c        = s_axi_arvalid && s_axi_arready;
    wr_addr_c      = (w_state_q == W_WAIT_DATA) ? aw_addr_q : s_axi_awaddr;
    wr_data_c      = (w_state_q == W_WAIT_ADDR) ? w_data_q : s_axi_wdata;
    wr_strb_c      = (w_state_q == W_WAIT_ADDR) ? w_strb_q : s_axi_wstrb[NBYTES-1:0];
    wstrb_unused_c = s_axi_wstrb[NBYTES];
  end

  axi_lite_addr_decode #(.ADDR_WIDTH(ADDR_WIDTH), .BASE_ADDR(BASE_ADDR)) u_aw_decode (
    .addr       (wr_addr_c),
    .legal_c    (wr_legal_c),
    .index_c    (wr_index_c),
    .writable_c (wr_writable_c)
  );

  axi_lite_addr_decode #(.ADDR_WIDTH(ADDR_WIDTH), .BASE_ADDR(BASE_ADDR)) u_ar_decode (
    .addr       (s_axi_araddr),
    .legal_c    (ar_legal_c),
    .index_c    (ar_index_c),
    .writable_c (ar_writable_unused_c)
  );

  // Write FSM next state and next registered outputs.
  always_comb begin
    w_state_d  = w_state_q;
    commit_c   = 1'b0;
    latch_aw_c = 1'b0;
    latch_w_c  = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        if (aw_hs_c && w_hs_c) begin
          commit_c  = 1'b1;
          w_state_d = W_RESP;
        end else if (aw_hs_c) begin
          latch_aw_c = 1'b1;
          w_state_d  = W_WAIT_DATA;
        end else if (w_hs_c) begin
          latch_w_c = 1'b1;
          w_state_d = W_WAIT_ADDR;
        end
      end
      W_WAIT_DATA: if (w_hs_c) begin
        commit_c  = 1'b1;
        w_state_d = W_RESP;
      end
      W_WAIT_ADDR: if (aw_hs_c) begin
        commit_c  = 1'b1;
        w_state_d = W_RESP;
      end
      W_RESP: if (s_axi_bready) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
    awready_d = (w_state_d == W_IDLE) || (w_state_d == W_WAIT_ADDR);
    wready_d  = (w_state_d == W_IDLE) || (w_state_d == W_WAIT_DATA);
    bvalid_d  = (w_state_d == W_RESP);
    bresp_d   = s_axi_bresp;
    if (commit_c) bresp_d = wr_writable_c ? RESP_WIDTH'(RESP_OKAY) : RESP_WIDTH'(RESP_SLVERR);
  end

  // Write FSM state, handshake outputs and latched address/data halves.
  always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
    if (s_axi_areset) begin
      w_state_q     <= W_IDLE;
      s_axi_awready <= 1'b0;
      s_axi_wready  <= 1'b0;
      s_axi_bvalid  <= 1'b0;
      s_axi_bresp   <= '0;
      aw_addr_q     <= '0;
      w_data_q      <= '0;
      w_strb_q      <= '0;
    end else begin
      w_state_q     <= w_state_d;
      s_axi_awready <= awready_d;
      s_axi_wready  <= wready_d;
      s_axi_bvalid  <= bvalid_d;
      s_axi_bresp   <= bresp_d;
      if (latch_aw_c) aw_addr_q <= s_axi_awaddr;
      if (latch_w_c) begin
        w_data_q <= s_axi_wdata;
        w_strb_q <= s_axi_wstrb[NBYTES-1:0];
      end
    end
  end

  // Register file: byte-strobed RW registers and the successful-write counter.
  always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
    if (s_axi_areset) begin
      reg0_q <= '0;
      reg1_q <= '0;
      reg2_q <= '0;
    end else if (commit_c && wr_writable_c) begin
      for (int i = 0; i < NBYTES; i++) begin
        if (wr_strb_c[i]) begin
          if (wr_index_c == 2'd0) reg0_q[i*8 +: 8] <= wr_data_c[i*8 +: 8];
          if (wr_index_c == 2'd1) reg1_q[i*8 +: 8] <= wr_data_c[i*8 +: 8];
        end
      end
      reg2_q <= reg2_q + DATA_WIDTH'(1);
    end
  end

  // Read data mux; sees pre-commit register values on a same-edge write.
  always_comb begin
    case ({ar_index_c, 2'b00})
      REG0_OFF: rd_mux_c = reg0_q;
      REG1_OFF: rd_mux_c = reg1_q;
      REG2_OFF: rd_mux_c = reg2_q;
      REG3_OFF: rd_mux_c = ID_VALUE;
      default:  rd_mux_c = '0;
    endcase
  end

  // Read FSM next state and next registered outputs.
  always_comb begin
    r_state_d = r_state_q;
    rdata_d   = s_axi_rdata;
    rresp_d   = s_axi_rresp;
    case (r_state_q)
      R_IDLE: if (ar_hs_c) begin
        r_state_d = R_DATA;
        rdata_d   = ar_legal_c ? rd_mux_c : '0;
        rresp_d   = ar_legal_c ? RESP_WIDTH'(RESP_OKAY) : RESP_WIDTH'(RESP_SLVERR);
      end
      R_DATA: if (s_axi_rready) r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
    arready_d = (r_state_d == R_IDLE);
    rvalid_d  = (r_state_d == R_DATA);
  end

  // Read FSM state and read channel outputs.
  always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
    if (s_axi_areset) begin
      r_state_q     <= R_IDLE;
      s_axi_arready <= 1'b0;
      s_axi_rvalid  <= 1'b0;
      s_axi_rdata   <= '0;
      s_axi_rresp   <= '0;
    end else begin
      r_state_q     <= r_state_d;
      s_axi_arready <= arready_d;
      s_axi_rvalid  <= rvalid_d;
      s_axi_rdata   <= rdata_d;
      s_axi_rresp   <= rresp_d;
    end
  end

endmodule

// File: tb/tb_axi_lite_reg_slave.sv
// Directed self-checking bench for axi_lite_reg_slave.
module tb_axi_lite_reg_slave;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  awaddr, araddr;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] wdata, rdata;
  logic [4:0]  wstrb;
  logic [2:0]  bresp, rresp;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] rd;
  logic [2:0]  rs;

  localparam logic [31:0] ID_VALUE = 32'hA5A5_0001;

  always #5 clk = ~clk;

  axi_lite_reg_slave dut (
    .s_axi_aclk    (clk),
    .s_axi_areset  (rst),
    .s_axi_awaddr  (awaddr),
    .s_axi_awvalid (awvalid),
    .s_axi_awready (awready),
    .s_axi_wdata   (wdata),
    .s_axi_wstrb   (wstrb),
    .s_axi_wvalid  (wvalid),
    .s_axi_wready  (wready),
    .s_axi_bresp   (bresp),
    .s_axi_bvalid  (bvalid),
    .s_axi_bready  (bready),
    .s_axi_araddr  (araddr),
    .s_axi_arvalid (arvalid),
    .s_axi_arready (arready),
    .s_axi_rdata   (rdata),
    .s_axi_rresp   (rresp),
    .s_axi_rvalid  (rvalid),
    .s_axi_rready  (rready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic axi_write(input logic [7:0] addr, input logic [31:0] data,
                           input logic [4:0] strb, output logic [2:0] resp);
    bit aw_done = 0;
    bit w_done  = 0;
    bit got     = 0;
    bit aw_hs, w_hs;
    resp = 3'b111;
    awaddr = addr; awvalid = 1'b1;
    wdata = data; wstrb = strb; wvalid = 1'b1;
    for (int c = 0; c < 20 && !(aw_done && w_done); c++) begin
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      tick();
      if (aw_hs) begin awvalid = 1'b0; aw_done = 1; end
      if (w_hs)  begin wvalid  = 1'b0; w_done  = 1; end
    end
    chk("wr_accept", 32'(aw_done && w_done), 32'd1);
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
    for (int c = 0; c < 20 && !got; c++) begin
      if (bvalid) begin resp = bresp; got = 1; end
      tick();
    end
    bready = 1'b0;
    chk("wr_resp_seen", 32'(got), 32'd1);
  endtask

  task automatic axi_read(input logic [7:0] addr, output logic [31:0] data, output logic [2:0] resp);
    bit done = 0;
    bit got  = 0;
    bit hs;
    data = 32'hDEAD_DEAD; resp = 3'b111;
    araddr = addr; arvalid = 1'b1;
    for (int c = 0; c < 20 && !done; c++) begin
      hs = arvalid && arready;
      tick();
      if (hs) begin arvalid = 1'b0; done = 1; end
    end
    chk("rd_accept", 32'(done), 32'd1);
    arvalid = 1'b0; rready = 1'b1;
    for (int c = 0; c < 20 && !got; c++) begin
      if (rvalid) begin data = rdata; resp = rresp; got = 1; end
      tick();
    end
    rready = 1'b0;
    chk("rd_data_seen", 32'(got), 32'd1);
  endtask

  initial begin
    rst = 1'b1;
    awaddr = '0; awvalid = 0; wdata = '0; wstrb = '0; wvalid = 0; bready = 0;
    araddr = '0; arvalid = 0; rready = 0;
    tick(); tick();

    // Reset values
    chk("rst_awready", 32'(awready), 32'd0);
    chk("rst_wready",  32'(wready),  32'd0);
    chk("rst_arready", 32'(arready), 32'd0);
    chk("rst_bvalid",  32'(bvalid),  32'd0);
    chk("rst_rvalid",  32'(rvalid),  32'd0);
    chk("rst_rdata",   rdata,        32'd0);
    rst = 1'b0;
    chk("rel_awready_low", 32'(awready), 32'd0);
    tick();
    chk("rel_awready", 32'(awready), 32'd1);
    chk("rel_wready",  32'(wready),  32'd1);
    chk("rel_arready", 32'(arready), 32'd1);

    // 1: AW and W together, 1-cycle write latency
    awaddr = 8'h00; awvalid = 1; wdata = 32'h1234_5678; wstrb = 5'h0F; wvalid = 1;
    tick();
    awvalid = 0; wvalid = 0;
    chk("t1_bvalid", 32'(bvalid), 32'd1);
    chk("t1_bresp",  32'(bresp),  32'd0);
    chk("t1_awready_busy", 32'(awready), 32'd0);
    bready = 1; tick(); bready = 0;
    chk("t1_bvalid_clr", 32'(bvalid), 32'd0);
    axi_read(8'h00, rd, rs);
    chk("t1_rd_reg0", rd, 32'h1234_5678);
    chk("t1_rresp",   32'(rs), 32'd0);
    axi_read(8'h08, rd, rs);
    chk("t1_rd_reg2", rd, 32'd1);

    // 2: W three cycles ahead of AW, partial strobes (ignored top strobe bit set)
    wdata = 32'hFFFF_FFFF; wstrb = 5'b10101; wvalid = 1;
    tick();
    wvalid = 0;
    for (int i = 0; i < 3; i++) begin
      chk("t2_wready_wait", 32'(wready), 32'd0);
      chk("t2_awready_wait", 32'(awready), 32'd1);
      if (i < 2) tick();
    end
    awaddr = 8'h04; awvalid = 1;
    tick();
    awvalid = 0;
    chk("t2_bvalid", 32'(bvalid), 32'd1);
    chk("t2_bresp",  32'(bresp),  32'd0);
    bready = 1; tick(); bready = 0;
    axi_read(8'h04, rd, rs);
    chk("t2_rd_reg1", rd, 32'h00FF_00FF);

    // 3: error responses, count unchanged
    axi_write(8'h08, 32'h1111_1111, 5'h0F, rs);
    chk("t3_wr_reg2_slverr", 32'(rs), 32'd2);
    axi_write(8'h02, 32'h2222_2222, 5'h0F, rs);
    chk("t3_wr_misalign_slverr", 32'(rs), 32'd2);
    axi_write(8'h10, 32'h3333_3333, 5'h0F, rs);
    chk("t3_wr_oow_slverr", 32'(rs), 32'd2);
    axi_read(8'h08, rd, rs);
    chk("t3_reg2_unchanged", rd, 32'd2);
    axi_read(8'h00, rd, rs);
    chk("t3_reg0_unchanged", rd, 32'h1234_5678);
    axi_read(8'h14, rd, rs);
    chk("t3_rd_oow_data", rd, 32'd0);
    chk("t3_rd_oow_resp", 32'(rs), 32'd2);
    axi_read(8'h0C, rd, rs);
    chk("t3_rd_id", rd, ID_VALUE);
    chk("t3_rd_id_resp", 32'(rs), 32'd0);

    // 4: backpressure on B and R
    awaddr = 8'h00; awvalid = 1; wdata = 32'd5; wstrb = 5'h0F; wvalid = 1;
    tick();
    awvalid = 0; wvalid = 0;
    for (int i = 0; i < 5; i++) begin
      chk("t4_bvalid_hold", 32'(bvalid), 32'd1);
      chk("t4_bresp_hold", 32'(bresp), 32'd0);
      chk("t4_awready_hold", 32'(awready), 32'd0);
      chk("t4_wready_hold", 32'(wready), 32'd0);
      tick();
    end
    bready = 1; tick(); bready = 0;
    chk("t4_bvalid_clr", 32'(bvalid), 32'd0);
    araddr = 8'h00; arvalid = 1;
    tick();
    arvalid = 0;
    for (int i = 0; i < 5; i++) begin
      chk("t4_rvalid_hold", 32'(rvalid), 32'd1);
      chk("t4_rdata_hold", rdata, 32'd5);
      chk("t4_arready_hold", 32'(arready), 32'd0);
      tick();
    end
    rready = 1; tick(); rready = 0;
    chk("t4_rvalid_clr", 32'(rvalid), 32'd0);

    // 5: same-edge read and write commit return pre-write values
    awaddr = 8'h00; awvalid = 1; wdata = 32'd9; wstrb = 5'h0F; wvalid = 1;
    araddr = 8'h00; arvalid = 1;
    tick();
    awvalid = 0; wvalid = 0; arvalid = 0;
    chk("t5_rdata_prewrite", rdata, 32'd5);
    chk("t5_bvalid", 32'(bvalid), 32'd1);
    bready = 1; rready = 1; tick(); bready = 0; rready = 0;
    axi_read(8'h00, rd, rs);
    chk("t5_rd_postwrite", rd, 32'd9);
    awaddr = 8'h04; awvalid = 1; wdata = 32'd0; wstrb = 5'h0F; wvalid = 1;
    araddr = 8'h08; arvalid = 1;
    tick();
    awvalid = 0; wvalid = 0; arvalid = 0;
    chk("t5_reg2_preinc", rdata, 32'd4);
    bready = 1; rready = 1; tick(); bready = 0; rready = 0;
    axi_read(8'h08, rd, rs);
    chk("t5_reg2_postinc", rd, 32'd5);
    axi_write(8'h04, 32'hABCD_EF01, 5'h00, rs);
    chk("t5_zero_strb_okay", 32'(rs), 32'd0);
    axi_read(8'h04, rd, rs);
    chk("t5_zero_strb_nochange", rd, 32'd0);
    axi_read(8'h08, rd, rs);
    chk("t5_zero_strb_counts", rd, 32'd6);

    // 6: reset mid-transaction
    awaddr = 8'h00; awvalid = 1; araddr = 8'h04; arvalid = 1;
    tick();
    awvalid = 0; arvalid = 0;
    chk("t6_in_wait_data", 32'(wready && !awready), 32'd1);
    chk("t6_in_r_data", 32'(rvalid), 32'd1);
    rst = 1;
    #1;
    chk("t6_rst_bvalid", 32'(bvalid), 32'd0);
    chk("t6_rst_rvalid", 32'(rvalid), 32'd0);
    chk("t6_rst_wready", 32'(wready), 32'd0);
    chk("t6_rst_rdata",  rdata, 32'd0);
    tick();
    rst = 0;
    tick();
    axi_read(8'h00, rd, rs);
    chk("t6_reg0_cleared", rd, 32'd0);
    axi_read(8'h04, rd, rs);
    chk("t6_reg1_cleared", rd, 32'd0);
    axi_read(8'h08, rd, rs);
    chk("t6_reg2_cleared", rd, 32'd0);
    axi_write(8'h04, 32'hCAFE_BABE, 5'h0F, rs);
    chk("t6_wr_okay", 32'(rs), 32'd0);
    axi_read(8'h04, rd, rs);
    chk("t6_rd_back", rd, 32'hCAFE_BABE);
    axi_read(8'h08, rd, rs);
    chk("t6_count", rd, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
